// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: word-addressed data memory plus the EX->WB register set,
// with hold (stall) and bubble (flush) control from hazard logic.
module memory_access_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        RW_0,
  input  logic [4:0]  DA_0,
  input  logic [1:0]  MD_0,
  input  logic        MW_0,
  input  logic        NxorV_0,
  input  logic [31:0] F_0,
  input  logic [31:0] BUS_A_0,
  input  logic [31:0] BUS_B_0,
  output logic        RW_1,
  output logic [4:0]  DA_1,
  output logic [1:0]  MD_1,
  output logic        NxorV,
  output logic [31:0] FUNC_OUT,
  output logic [31:0] DATA_OUT,
  output logic        addr_err
);

  logic [31:0]       r_mem [DEPTH];
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_we;

  // Full-width compare so addresses above DEPTH never alias onto low words.
  assign w_in_range = (BUS_A_0 < 32'(DEPTH));
  assign w_idx      = BUS_A_0[ADDR_W-1:0];
  assign w_we       = !reset && !stall && !flush && MW_0 && w_in_range;

  always_ff @(posedge CLK) begin
    if (reset) begin
      RW_1     <= 1'b0;
      DA_1     <= '0;
      MD_1     <= '0;
      NxorV    <= 1'b0;
      FUNC_OUT <= '0;
      DATA_OUT <= '0;
      addr_err <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        RW_1     <= 1'b0;
        DA_1     <= '0;
        MD_1     <= '0;
        NxorV    <= 1'b0;
        FUNC_OUT <= '0;
        DATA_OUT <= '0;
        addr_err <= 1'b0;
      end else begin
        RW_1     <= RW_0;
        DA_1     <= DA_0;
        MD_1     <= MD_0;
        NxorV    <= NxorV_0;
        FUNC_OUT <= F_0;
        // Read samples the pre-write word, giving read-before-write on a same-cycle store.
        if (w_in_range) begin
          DATA_OUT <= r_mem[w_idx];
          addr_err <= 1'b0;
        end else begin
          DATA_OUT <= '0;
          addr_err <= 1'b1;
        end
      end
    end
  end

  // Memory has no reset: contents survive a pipeline reset.
  always_ff @(posedge CLK) begin
    if (w_we) r_mem[w_idx] <= BUS_B_0;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: behavioural model checked every cycle, plus directed literals.
module tb_memory_access_stage;
  localparam int DEPTH = 256;

  logic        CLK = 0;
  logic        reset, stall, flush, RW_0, MW_0, NxorV_0;
  logic [4:0]  DA_0;
  logic [1:0]  MD_0;
  logic [31:0] F_0, BUS_A_0, BUS_B_0;
  logic        RW_1, NxorV, addr_err;
  logic [4:0]  DA_1;
  logic [1:0]  MD_1;
  logic [31:0] FUNC_OUT, DATA_OUT;

  memory_access_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .CLK(CLK), .reset(reset), .stall(stall), .flush(flush),
    .RW_0(RW_0), .DA_0(DA_0), .MD_0(MD_0), .MW_0(MW_0), .NxorV_0(NxorV_0),
    .F_0(F_0), .BUS_A_0(BUS_A_0), .BUS_B_0(BUS_B_0),
    .RW_1(RW_1), .DA_1(DA_1), .MD_1(MD_1), .NxorV(NxorV),
    .FUNC_OUT(FUNC_OUT), .DATA_OUT(DATA_OUT), .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array plus the expected output set.
  logic [31:0] mm     [DEPTH];
  bit          mm_vld [DEPTH];
  logic        e_rw = 0, e_nv = 0, e_err = 0;
  logic [4:0]  e_da = 0;
  logic [1:0]  e_md = 0;
  logic [31:0] e_f = 0, e_data = 0;
  bit          e_dvld = 1;
  bit          check_en = 0;

  initial for (int i = 0; i < DEPTH; i++) mm_vld[i] = 0;

  always @(posedge CLK) begin
    if (reset) begin
      e_rw = 0; e_da = 0; e_md = 0; e_nv = 0; e_f = 0; e_data = 0; e_err = 0; e_dvld = 1;
    end else if (stall) begin
      // outputs hold
    end else if (flush) begin
      e_rw = 0; e_da = 0; e_md = 0; e_nv = 0; e_f = 0; e_data = 0; e_err = 0; e_dvld = 1;
    end else begin
      e_rw = RW_0; e_da = DA_0; e_md = MD_0; e_nv = NxorV_0; e_f = F_0;
      if (BUS_A_0 < DEPTH) begin
        e_data = mm[BUS_A_0];
        e_dvld = mm_vld[BUS_A_0];
        e_err  = 0;
        if (MW_0) begin
          mm[BUS_A_0]     = BUS_B_0;
          mm_vld[BUS_A_0] = 1;
        end
      end else begin
        e_data = 0; e_dvld = 1; e_err = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      check("RW_1", 32'(RW_1), 32'(e_rw));
      check("DA_1", 32'(DA_1), 32'(e_da));
      check("MD_1", 32'(MD_1), 32'(e_md));
      check("NxorV", 32'(NxorV), 32'(e_nv));
      check("FUNC_OUT", FUNC_OUT, e_f);
      check("addr_err", 32'(addr_err), 32'(e_err));
      if (e_dvld) check("DATA_OUT", DATA_OUT, e_data);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; RW_0 = 0; MW_0 = 0; NxorV_0 = 0;
    DA_0 = 0; MD_0 = 0; F_0 = 0; BUS_A_0 = 0; BUS_B_0 = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle(); MW_0 = 1; BUS_A_0 = a; BUS_B_0 = d; cyc();
  endtask

  task automatic load(input logic [31:0] a);
    idle(); MD_0 = 1; RW_0 = 1; DA_0 = 5'(a); BUS_A_0 = a; cyc();
  endtask

  logic [31:0] h_f, h_data;

  initial begin
    idle();
    // 1: reset with live inputs, then release
    reset = 1; RW_0 = 1; F_0 = 32'hFFFFFFFF; BUS_A_0 = 32'h1000;
    cyc(); check_en = 1;
    cyc();
    check("rst FUNC_OUT", FUNC_OUT, 32'h0);
    check("rst RW_1", 32'(RW_1), 32'h0);
    check("rst DATA_OUT", DATA_OUT, 32'h0);
    reset = 0;
    cyc();
    check("rel FUNC_OUT", FUNC_OUT, 32'hFFFFFFFF);
    check("rel RW_1", 32'(RW_1), 32'h1);

    // Preload every word so all later reads are defined
    for (int i = 0; i < DEPTH; i++) store(32'(i), $urandom);

    // 2: store then load
    store(5, 32'hFECDA097);
    load(5);
    check("ld DATA_OUT", DATA_OUT, 32'hFECDA097);
    check("ld MD_1", 32'(MD_1), 32'h1);
    check("ld DA_1", 32'(DA_1), 32'h5);

    // 3: read-before-write on same-cycle store
    store(7, 32'hAA999AFE);
    idle(); MW_0 = 1; BUS_A_0 = 7; BUS_B_0 = 32'h12345678; cyc();
    check("rbw old", DATA_OUT, 32'hAA999AFE);
    load(7);
    check("rbw new", DATA_OUT, 32'h12345678);

    // 4: stall holds outputs and blocks writes; stall beats flush
    store(20, 32'h55AA55AA);
    idle(); F_0 = 32'h1111; RW_0 = 1; DA_0 = 3; BUS_A_0 = 20; cyc();
    h_f = FUNC_OUT; h_data = DATA_OUT;
    check("pre-stall F", h_f, 32'h1111);
    for (int k = 0; k < 3; k++) begin
      stall = 1; MW_0 = 1; BUS_A_0 = 20; BUS_B_0 = $urandom; F_0 = $urandom; RW_0 = 0;
      cyc();
      check("stall FUNC_OUT", FUNC_OUT, 32'h1111);
      check("stall DATA_OUT", DATA_OUT, 32'h55AA55AA);
    end
    flush = 1; cyc();
    check("stall+flush F", FUNC_OUT, 32'h1111);
    check("stall+flush RW", 32'(RW_1), 32'h1);
    load(20);
    check("stall no-write", DATA_OUT, 32'h55AA55AA);

    // 5: flush inserts bubble and blocks write
    store(9, 32'hC0FFEE00);
    idle(); flush = 1; RW_0 = 1; MW_0 = 1; MD_0 = 2; BUS_A_0 = 9; BUS_B_0 = 32'h1; F_0 = 32'h77;
    cyc();
    check("flush RW_1", 32'(RW_1), 32'h0);
    check("flush MD_1", 32'(MD_1), 32'h0);
    check("flush DATA_OUT", DATA_OUT, 32'h0);
    load(9);
    check("flush no-write", DATA_OUT, 32'hC0FFEE00);

    // 6: out of range, no aliasing onto word 0
    store(0, 32'h0BADF00D);
    idle(); MW_0 = 1; BUS_A_0 = 32'h100; BUS_B_0 = 32'hDEADBEEF; F_0 = 32'h42; cyc();
    check("oob addr_err", 32'(addr_err), 32'h1);
    check("oob DATA_OUT", DATA_OUT, 32'h0);
    check("oob FUNC_OUT", FUNC_OUT, 32'h42);
    load(0);
    check("oob clear err", 32'(addr_err), 32'h0);
    check("oob mem0", DATA_OUT, 32'h0BADF00D);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 5) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      RW_0    = 1'($urandom);
      MW_0    = 1'($urandom);
      NxorV_0 = 1'($urandom);
      DA_0    = 5'($urandom);
      MD_0    = 2'($urandom_range(0, 2));
      F_0     = $urandom;
      BUS_B_0 = $urandom;
      case ($urandom_range(0, 9))
        0:       BUS_A_0 = $urandom;
        1:       BUS_A_0 = 32'(DEPTH) + 32'($urandom_range(0, 3));
        2:       BUS_A_0 = 32'(DEPTH - 1);
        default: BUS_A_0 = 32'($urandom_range(0, 15));
      endcase
      cyc();
    end

    idle(); cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
